register_file: RTL and testbench

32 × 32-bit MIPS general-purpose register file for the single-cycle datapath. It sits directly downstream of the RegDst write-register mux and consumes its 5-bit `Write_Register` output as the write address. It supplies the two operands to the ALU-source mux and the ALU. There is one synchronous write port, two combinational read ports, `$zero` hard-wired to 0, and optional same-cycle write-to-read bypass.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/register_file_read_port.sv | 42 ++++
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the single-cycle MIPS datapath.
//   REG_ADDR_W : width of a register index (5 -> 32 registers)
//   WORD_W     : machine word width
//   REG_ZERO   : index of $zero, hard-wired to 0
//   REG_SP     : index of $sp, used by stack logic
//   REG_RA     : index of $ra, written by jal
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file.
//   rst_n   : in  - reset (active-low); bypass is gated off while low
//   wr_en   : in  - write enable of the write port this cycle
//   wr_addr : in  - write index of the write port this cycle
//   wr_data : in  - write value of the write port this cycle
//   rd_addr : in  - index to read
//   regs    : in  - full stored register array
//   rd_data : out - selected value
// Priority: index 0 reads 0, then same-cycle write forwarding (when
// BYPASS is enabled), then the stored entry.
// ---------------------------------------------------------------------------
module rf_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  output logic [DATA_W-1:0] rd_data
);

  // Later assignments override earlier ones, so the zero check is applied
  // last to give it the highest priority.
  always_comb begin
    rd_data = regs[rd_addr];
    if ((BYPASS != 0) && rst_n && wr_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end
    if (rd_addr == '0) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32 x 32-bit MIPS general-purpose register file: one synchronous write
// port, two combinational read ports, $zero hard-wired to 0, optional
// same-cycle write-to-read bypass.
//   clk             : in  - clock, rising edge
//   rst_n           : in  - synchronous active-low reset, clears all entries
//   RegWrite        : in  - write enable
//   Write_Register  : in  - write index (from RegDst mux)
//   Write_Data      : in  - write value
//   Read_Register_1 : in  - read index A
//   Read_Register_2 : in  - read index B
//   Read_Data_1     : out - contents of register A
//   Read_Data_2     : out - contents of register B
// ---------------------------------------------------------------------------
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Read_Register_1,
  input  logic [ADDR_W-1:0] Read_Register_2,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // An unknown RegWrite or Write_Register makes the if-condition / array
  // index unknown, which leaves the array untouched in simulation.
  always_comb begin
    mem_d = mem_q;
    if (RegWrite && (Write_Register != '0)) begin
      mem_d[Write_Register] = Write_Data;
    end
  end

  // Reset wins over a concurrent write; that write is simply lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Simulation-only diagnostic for unknown write controls.
  always @(posedge clk) begin
    if (rst_n && $isunknown(RegWrite)) begin
      $warning("register_file: RegWrite is unknown (%b), write ignored", RegWrite);
    end else if (rst_n && (RegWrite === 1'b1) && $isunknown(Write_Register)) begin
      $warning("register_file: Write_Register is unknown (%b), write ignored", Write_Register);
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_read_a (
    .rst_n   (rst_n),
    .wr_en   (RegWrite),
    .wr_addr (Write_Register),
    .wr_data (Write_Data),
    .rd_addr (Read_Register_1),
    .regs    (mem_q),
    .rd_data (Read_Data_1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_read_b (
    .rst_n   (rst_n),
    .wr_en   (RegWrite),
    .wr_addr (Write_Register),
    .wr_data (Write_Data),
    .rd_addr (Read_Register_2),
    .regs    (mem_q),
    .rd_data (Read_Data_2)
  );

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Drives one bypassing and one non-bypassing register_file with the same
// inputs and compares both against an array model of the register file.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd1_b, rd2_b;
  logic [31:0] rd1_n, rd2_n;

  int checks;
  int failures;

  logic [31:0] model [32];
  bit          model_valid;

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
    .clk             (clk),
    .rst_n           (rst_n),
    .RegWrite        (reg_write),
    .Write_Register  (wr_reg),
    .Write_Data      (wr_data),
    .Read_Register_1 (rd_reg_1),
    .Read_Register_2 (rd_reg_2),
    .Read_Data_1     (rd1_b),
    .Read_Data_2     (rd2_b)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
    .clk             (clk),
    .rst_n           (rst_n),
    .RegWrite        (reg_write),
    .Write_Register  (wr_reg),
    .Write_Data      (wr_data),
    .Read_Register_1 (rd_reg_1),
    .Read_Register_2 (rd_reg_2),
    .Read_Data_1     (rd1_n),
    .Read_Data_2     (rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state update: what the register array must hold after
  // each rising edge.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_valid = 1'b1;
    end else if ((reg_write === 1'b1) && !$isunknown(wr_reg) && (wr_reg != 5'd0)) begin
      model[wr_reg] = wr_data;
    end
  end

  // Value a read port must show right now, given the current inputs.
  function automatic logic [31:0] expRead(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'h0;
    if (byp && (rst_n === 1'b1) && (reg_write === 1'b1) && (idx == wr_reg)) return wr_data;
    return model[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Commit the current inputs on the next rising edge, present the new
  // inputs shortly after it, then return at the falling edge where outputs
  // are settled.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] ra1,
                               input logic [4:0] ra2);
    @(posedge clk);
    #1;
    rst_n     = rst;
    reg_write = we;
    wr_reg    = wa;
    wr_data   = wd;
    rd_reg_1  = ra1;
    rd_reg_2  = ra2;
    @(negedge clk);
  endtask

  // Continuous comparison of all four read outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_rd1_byp",   rd1_b, expRead(rd_reg_1, 1'b1));
      checkOutput("model_rd2_byp",   rd2_b, expRead(rd_reg_2, 1'b1));
      checkOutput("model_rd1_nobyp", rd1_n, expRead(rd_reg_1, 1'b0));
      checkOutput("model_rd2_nobyp", rd2_n, expRead(rd_reg_2, 1'b0));
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    model_valid = 1'b0;
    rst_n       = 1'b0;
    reg_write   = 1'b0;
    wr_reg      = 5'd0;
    wr_data     = 32'h0;
    rd_reg_1    = 5'd0;
    rd_reg_2    = 5'd0;

    // Reset for one edge, then sweep every index.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'd0);
      checkOutput("reset_sweep_byp",   rd1_b, 32'h0);
      checkOutput("reset_sweep_nobyp", rd1_n, 32'h0);
    end

    // Write 8, then read it on both ports; 9 untouched.
    applyStimulus(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd9);
    checkOutput("wr8_same_cycle_byp",   rd1_b, 32'hDEADBEEF);
    checkOutput("wr8_same_cycle_nobyp", rd1_n, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
    checkOutput("rd8_port1", rd1_b, 32'hDEADBEEF);
    checkOutput("rd8_port2", rd2_b, 32'hDEADBEEF);
    checkOutput("rd8_port2_nobyp", rd2_n, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("rd9_zero", rd1_b, 32'h0);

    // $zero protection, same cycle and next cycle.
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    checkOutput("zero_same_cycle_byp",   rd1_b, 32'h0);
    checkOutput("zero_same_cycle_nobyp", rd1_n, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_next_cycle", rd1_b, 32'h0);

    // Bypass versus no bypass on index 3.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h2, 5'd0, 5'd3);
    checkOutput("bypass_on_same_cycle",  rd2_b, 32'h2);
    checkOutput("bypass_off_same_cycle", rd2_n, 32'h1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    checkOutput("bypass_on_next_cycle",  rd2_b, 32'h2);
    checkOutput("bypass_off_next_cycle", rd2_n, 32'h2);

    // Reset priority over a concurrent write to index 4.
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h00001234, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'hA5A5A5A5, 5'd4, 5'd4);
    checkOutput("bypass_gated_in_reset", rd1_b, 32'h00001234);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd8);
    checkOutput("reset_drops_write", rd1_b, 32'h0);
    checkOutput("reset_clears_8",    rd2_b, 32'h0);

    // Unknown write enable leaves index 7 alone.
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h55, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'bx, 5'd7, 32'h99, 5'd7, 5'd7);
    checkOutput("x_enable_same_cycle", rd1_b, 32'h55);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("x_enable_after_edge_byp",   rd1_b, 32'h55);
    checkOutput("x_enable_after_edge_nobyp", rd2_n, 32'h55);

    // Randomised traffic with address collisions and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        w;
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      r  = ($urandom_range(0, 39) != 0);
      w  = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 3));
      applyStimulus(r, w, wa, $urandom, a1, a2);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
